// File: rtl/muldiv_sched_if.sv
// Handshake bundle between the execute stage and the HI/LO mult/div sequencer.
//   master: pipeline side, drives the op request, flush and hold.
//   slave : sequencer side, returns the stall request, HI/LO results and busy.
interface muldiv_sched_if;
  logic        op_valid;
  logic [1:0]  op_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        pipe_hold;
  logic        stall_req;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;

  modport master (
    output op_valid, op_sel, src_a, src_b, flush, pipe_hold,
    input  stall_req, result_valid, hi_out, lo_out, busy
  );

  modport slave (
    input  op_valid, op_sel, src_a, src_b, flush, pipe_hold,
    output stall_req, result_valid, hi_out, lo_out, busy
  );
endinterface

// File: rtl/muldiv_sched.sv
// Multi-cycle sequencer for the HI/LO multiply/divide resource.
// Accepts MULT/MULTU/DIV/DIVU from E, runs a one-cycle multiplier or a
// 32-iteration restoring divider, stalls F/D/E until the result is ready,
// then holds HI/LO valid until the E stage is released.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_sched_if.slave: op_valid/op_sel/src_a/src_b/flush/pipe_hold
//          in; stall_req (combinational), result_valid/hi_out/lo_out
//          (registered), busy (state != IDLE) out
module muldiv_sched #(
  parameter int unsigned DIV_ITERS = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_sched_if.slave bus
);

  localparam int unsigned XW = 32;
  localparam int unsigned PW = 2 * XW;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [XW-1:0] opa;      // multiplicand, or dividend magnitude shifting into quotient
  logic [XW-1:0] opb;      // multiplier, or divisor magnitude
  logic [XW-1:0] rem;      // partial remainder
  logic [XW-1:0] hi_q;
  logic [XW-1:0] lo_q;
  logic [CW-1:0] cnt;
  logic          sx;       // signed operation (MULT/DIV)
  logic          neg_q;
  logic          neg_r;
  logic          rv_q;

  // Request decode in IDLE
  logic          accept_c;
  logic          sgn_in_c;
  logic [XW-1:0] abs_a_c;
  logic [XW-1:0] abs_b_c;

  assign accept_c = (state == S_IDLE) & bus.op_valid & ~bus.flush;
  assign sgn_in_c = ~bus.op_sel[0];
  assign abs_a_c  = (sgn_in_c & bus.src_a[31]) ? (~bus.src_a + XW'(1)) : bus.src_a;
  assign abs_b_c  = (sgn_in_c & bus.src_b[31]) ? (~bus.src_b + XW'(1)) : bus.src_b;

  // Multiplier: low 64 bits of the product of 64-bit extended operands
  logic [PW-1:0] ext_a_c;
  logic [PW-1:0] ext_b_c;
  logic [PW-1:0] prod_c;

  assign ext_a_c = {{XW{sx & opa[XW-1]}}, opa};
  assign ext_b_c = {{XW{sx & opb[XW-1]}}, opb};
  assign prod_c  = ext_a_c * ext_b_c;

  // One restoring-divide step; the remainder always stays below the divisor
  logic [XW:0]   rem_sh_c;
  logic          ge_c;
  logic [XW-1:0] rem_nx_c;
  logic [XW-1:0] quo_nx_c;
  logic [XW-1:0] quo_fix_c;
  logic [XW-1:0] rem_fix_c;
  logic          last_c;

  assign rem_sh_c  = {rem, opa[XW-1]};
  assign ge_c      = rem_sh_c >= {1'b0, opb};
  assign rem_nx_c  = ge_c ? XW'(rem_sh_c - {1'b0, opb}) : rem_sh_c[XW-1:0];
  assign quo_nx_c  = {opa[XW-2:0], ge_c};
  assign quo_fix_c = neg_q ? (~quo_nx_c + XW'(1)) : quo_nx_c;
  assign rem_fix_c = neg_r ? (~rem_nx_c + XW'(1)) : rem_nx_c;
  assign last_c    = (cnt == CW'(DIV_ITERS - 1));

  // Sequencer state, operand latches and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt   <= '0;
      sx    <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rv_q  <= 1'b0;
    end else if (bus.flush) begin
      // Abandon the op; HI/LO keep whatever they last held
      state <= S_IDLE;
      cnt   <= '0;
      rv_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            sx <= sgn_in_c;
            if (!bus.op_sel[1]) begin
              opa   <= bus.src_a;
              opb   <= bus.src_b;
              state <= S_MUL;
            end else if (bus.src_b == '0) begin
              hi_q  <= bus.src_a;
              lo_q  <= '1;
              rv_q  <= 1'b1;
              state <= S_DONE;
            end else begin
              opa   <= abs_a_c;
              opb   <= abs_b_c;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= sgn_in_c & (bus.src_a[31] ^ bus.src_b[31]);
              neg_r <= sgn_in_c & bus.src_a[31];
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          hi_q  <= prod_c[PW-1:XW];
          lo_q  <= prod_c[XW-1:0];
          rv_q  <= 1'b1;
          state <= S_DONE;
        end
        S_DIV: begin
          opa <= quo_nx_c;
          rem <= rem_nx_c;
          if (last_c) begin
            cnt   <= '0;
            lo_q  <= quo_fix_c;
            hi_q  <= rem_fix_c;
            rv_q  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          // op_valid is ignored here so the held instruction is not re-issued
          if (!bus.pipe_hold) begin
            rv_q  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_req    = ~bus.flush & (accept_c | (state == S_MUL) | (state == S_DIV));
  assign bus.result_valid = rv_q;
  assign bus.hi_out       = hi_q;
  assign bus.lo_out       = lo_q;
  assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched.
module tb_muldiv_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  muldiv_sched_if bus ();

  muldiv_sched #(.DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.src_a    = a;
    bus.src_b    = b;
  endtask

  // Drop the request and scramble operands to show they were latched
  task automatic drop_op();
    bus.op_valid = 1'b0;
    bus.op_sel   = 2'b00;
    bus.src_a    = 32'hDEAD_BEEF;
    bus.src_b    = 32'h1234_5678;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_sel = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.pipe_hold = 1'b0;
    tick(); tick();
    #1;
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", bus.result_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
    total++; if (bus.hi_out !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi_out); end
    total++; if (bus.lo_out !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo_out); end
    rst = 1'b0;
  endtask

  task automatic test_mult();
    tick(); drive_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005); #1;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL mult_stall_t0 got=%b exp=1", bus.stall_req); end
    tick(); drop_op(); #1;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL mult_stall_t1 got=%b exp=1", bus.stall_req); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mult_busy_t1 got=%b exp=1", bus.busy); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL mult_rv_t1 got=%b exp=0", bus.result_valid); end
    tick(); #1;
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL mult_rv_t2 got=%b exp=1", bus.result_valid); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL mult_stall_t2 got=%b exp=0", bus.stall_req); end
    total++; if (bus.hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi_out); end
    total++; if (bus.lo_out !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff1", bus.lo_out); end
    tick(); #1;
    total++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin bad++; $display("FAIL mult_idle busy=%b rv=%b exp=0/0", bus.busy, bus.result_valid); end
  endtask

  task automatic test_mult_signedness();
    tick(); drive_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); drop_op();
    tick(); #1;
    total++; if (bus.hi_out !== 32'hFFFF_FFFE || bus.lo_out !== 32'h0000_0001) begin bad++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", bus.hi_out, bus.lo_out); end
    tick(); drive_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); drop_op();
    tick(); #1;
    total++; if (bus.result_valid !== 1'b1) begin bad++; $display("FAIL mult_m1_rv got=%b exp=1", bus.result_valid); end
    total++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h1) begin bad++; $display("FAIL mult_m1 got=%h_%h exp=00000000_00000001", bus.hi_out, bus.lo_out); end
    tick();
  endtask

  // Issue one divide, count stall cycles and result latency, check HI/LO
  task automatic test_divide(input string name, input logic [1:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_lo,
                             input logic [31:0] exp_hi, input int exp_lat);
    int stalls;
    int lat;
    stalls = 0;
    lat    = 0;
    tick(); drive_op(sel, a, b); #1;
    if (bus.stall_req === 1'b1) stalls++;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      tick();
      if (c == 1) drop_op();
      #1;
      if (bus.result_valid === 1'b1) lat = c;
      else if (bus.stall_req === 1'b1) stalls++;
    end
    total++; if (lat !== exp_lat) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    total++; if (stalls !== exp_lat) begin bad++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, stalls, exp_lat); end
    total++; if (bus.lo_out !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h exp=%h", name, bus.lo_out, exp_lo); end
    total++; if (bus.hi_out !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h exp=%h", name, bus.hi_out, exp_hi); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL %s_stall_done got=%b exp=0", name, bus.stall_req); end
    tick();
  endtask

  task automatic test_div();
    test_divide("div_neg7_2",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    test_divide("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33);
    test_divide("div_7_neg2",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 33);
    test_divide("divu_100_7",  2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 33);
    test_divide("divu_by0",    2'b11, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1);
  endtask

  // Flush and reset in the middle of a divide; HI/LO start at 5 / FFFF_FFFF
  task automatic test_flush_rst();
    int rv_seen;
    tick(); drive_op(2'b10, 32'd1000, 32'd3);
    tick(); drop_op();
    for (int c = 2; c <= 10; c++) tick();
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_busy_pre got=%b exp=1", bus.busy); end
    bus.flush = 1'b1; #1;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", bus.stall_req); end
    tick(); bus.flush = 1'b0; #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", bus.busy); end
    total++; if (bus.hi_out !== 32'h5 || bus.lo_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL flush_hold_hilo got=%h_%h exp=00000005_ffffffff", bus.hi_out, bus.lo_out); end
    rv_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.result_valid === 1'b1) rv_seen++;
      tick();
    end
    total++; if (rv_seen !== 0) begin bad++; $display("FAIL flush_no_rv got=%0d exp=0", rv_seen); end

    drive_op(2'b10, 32'd1000, 32'd3);
    tick(); drop_op();
    for (int c = 2; c <= 10; c++) tick();
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    total++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.stall_req !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl busy=%b rv=%b stall=%b exp=0/0/0", bus.busy, bus.result_valid, bus.stall_req); end
    total++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", bus.hi_out, bus.lo_out); end
  endtask

  // Hold DONE for 3 extra cycles with op_valid stuck high, then back-to-back issue
  task automatic test_back_to_back();
    int rv_cnt;
    tick(); drive_op(2'b00, 32'd6, 32'd7);
    tick(); #1;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL hold_stall_mul got=%b exp=1", bus.stall_req); end
    rv_cnt = 0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      bus.pipe_hold = (c <= 4);
      #1;
      if (bus.result_valid === 1'b1) rv_cnt++;
      total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL hold_stall_done_t%0d got=%b exp=0", c, bus.stall_req); end
    end
    total++; if (rv_cnt !== 4) begin bad++; $display("FAIL hold_rv_cycles got=%0d exp=4", rv_cnt); end
    total++; if (bus.lo_out !== 32'd42 || bus.hi_out !== 32'd0) begin bad++; $display("FAIL hold_result got=%h_%h exp=0_2a", bus.hi_out, bus.lo_out); end
    tick(); drive_op(2'b01, 32'd3, 32'd4); #1;
    total++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle rv=%b busy=%b exp=0/0", bus.result_valid, bus.busy); end
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL b2b_accept_stall got=%b exp=1", bus.stall_req); end
    tick(); drop_op(); #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
    tick(); #1;
    total++; if (bus.result_valid !== 1'b1 || bus.lo_out !== 32'd12 || bus.hi_out !== 32'd0) begin bad++; $display("FAIL b2b_result rv=%b got=%h_%h exp=1 0_c", bus.result_valid, bus.hi_out, bus.lo_out); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult();
    test_mult_signedness();
    test_div();
    test_flush_rst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle sequencer for the HI/LO multiply/divide resource. It sits beside the execute stage and accepts MULT, MULTU, DIV and DIVU once the decode stage has flagged them as HI/LO writers (both HI and LO written). It runs a single-cycle-issue multiplier or a 32-iteration restoring divider, and holds the pipeline with `stall_req` until the result is ready. It then presents HI/LO results for one accepted write.

## Interface
- `DIV_ITERS`, default 32: divider iterations, one quotient bit per cycle. Only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `op_valid`  in  1  the E-stage instruction is a mult/div op.
- `op_sel`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs value, the multiplicand or dividend.
- `src_b`  in  32  rt value, the multiplier or divisor.
- `flush`  in  1  cancel any in-flight op (exception or redirect).
- `pipe_hold`  in  1  E stage is held by another stall source.
- `stall_req`  out  1  hold the F/D/E stages; combinational.
- `result_valid`  out  1  `hi_out`/`lo_out` are valid for the E-stage op; registered.
- `hi_out`  out  32  HI result: product[63:32] or remainder.
- `lo_out`  out  32  LO result: product[31:0] or quotient.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - `op_valid & ~flush` accepts the op in cycle T.
  - Operands and `op_sel` are latched in that cycle.
  - MULT/MULTU → MUL.
  - DIV/DIVU with `src_b` != 0 → DIV.
  - DIV/DIVU with `src_b` == 0 → DONE directly, with `lo` = FFFF_FFFF and `hi` = `src_a`.
- MUL:
  - 64-bit product: signed for MULT, unsigned for MULTU.
  - Registered into hi/lo. Next state DONE.
- DIV:
  - Restoring algorithm on operand magnitudes; DIVU uses raw operands.
  - A 6-bit iteration counter runs 0..DIV_ITERS-1; on the last iteration → DONE.
  - On entry to DONE, signed results are fixed:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - 8000_0000 / FFFF_FFFF (DIV) gives lo = 8000_0000, hi = 0.
- DONE:
  - `result_valid` = 1.
  - Stays in DONE while `pipe_hold` = 1; → IDLE when `pipe_hold` = 0.
  - `op_valid` is ignored in DONE, so the same instruction is never re-issued.
- `stall_req` = (IDLE & `op_valid` & ~`flush`) | MUL | DIV, and is always 0 when `flush` = 1.
- `flush` has priority over everything:
  - → IDLE next cycle;
  - `result_valid` drops next cycle;
  - `hi_out`/`lo_out` keep their previous values;
  - the counter clears.
- `rst` has priority over `flush`. It is legal mid-operation and abandons the op.

## Timing
- Reset values:
  - state IDLE;
  - `hi_out` = `lo_out` = 0;
  - `result_valid` = 0, `busy` = 0, `stall_req` = 0 (with `op_valid` = 0);
  - counter 0.
- MULT/MULTU accepted at T:
  - MUL at T+1, DONE at T+2;
  - `stall_req` high at T and T+1;
  - `result_valid` and `hi_out`/`lo_out` valid from T+2.
- DIV/DIVU accepted at T:
  - DIV for T+1..T+32, DONE at T+33;
  - `stall_req` high for T..T+32 (33 cycles).
- Divide by zero: DONE at T+1; `stall_req` high at T only.
- DONE lasts ≥ 1 cycle, extended one cycle per cycle of `pipe_hold`.
- Back-to-back ops: the next op can be accepted in the first IDLE cycle after DONE. Minimum MULT-to-MULT issue spacing is 3 cycles.
- Operand changes after acceptance have no effect.

## Test plan
- MULT, `src_a` = FFFF_FFFD (-3), `src_b` = 5, accepted at T → `stall_req` high at T, T+1; at T+2 `result_valid` = 1, hi = FFFF_FFFF, lo = FFFF_FFF1.
- MULTU FFFF_FFFF × FFFF_FFFF → hi = FFFF_FFFE, lo = 0000_0001 at T+2. MULT with the same operands → hi = 0, lo = 1.
- DIV FFFF_FFF9 (-7) / 2 → `stall_req` high for 33 cycles; at T+33 lo = FFFF_FFFD, hi = FFFF_FFFF.
- DIV 8000_0000 / FFFF_FFFF → lo = 8000_0000, hi = 0.
- DIVU 100 / 7 → lo = 0000_000E, hi = 0000_0002 at T+33.
- DIVU 5 / 0 → lo = FFFF_FFFF, hi = 5 at T+1.
- DIV accepted at T, `flush` asserted at T+10 → `stall_req` = 0 at T+10, IDLE at T+11, no `result_valid`, hi/lo unchanged. Also: `rst` at T+10 → all outputs at their reset values at T+11.
- MULT completes with `pipe_hold` = 1 for 3 cycles while `op_valid` stays 1 → `result_valid` held for 4 cycles, no re-issue, `stall_req` = 0 throughout. A new op with `op_valid` asserted in the following IDLE cycle is accepted.
